// File: rtl/fpu_add_arbiter_pkg.sv
// Shared types and constants for the round-robin front end of the shared FP32 adder.
package fpu_add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } fpu_arb_state_t;

  localparam int FPU_NUM_REQ = 4;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_QNAN = 32'hFFC00000;

endpackage

// File: rtl/fpu_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module fpu_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

  // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit is the winner.
  logic [N-1:0]     win;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  assign win   = N'({req, req} >> ptr);
  assign valid = |req;

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (win[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one multi-cycle fpu_adder between N_REQ requesters, one operation in flight.
module fpu_add_arbiter
  import fpu_add_arbiter_pkg::*;
#(
  parameter int N_REQ = FPU_NUM_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_stb,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ack,
  output logic [N_REQ-1:0]      resp_stb,
  output logic [31:0]           resp_z,
  input  logic [N_REQ-1:0]      resp_ack,
  output logic [31:0]           fpu_input_a,
  output logic [31:0]           fpu_input_b,
  output logic                  fpu_input_stb,
  input  logic                  fpu_input_ack,
  input  logic [31:0]           fpu_output_z,
  input  logic                  fpu_output_stb,
  output logic                  fpu_output_ack,
  output logic                  busy,
  output logic [IDX_W-1:0]      cur_id
);

  fpu_arb_state_t   state_q;
  logic [IDX_W-1:0] rr_ptr_q, cur_id_q;
  logic [31:0]      op_a_q, op_b_q, res_z_q;
  logic [N_REQ-1:0] req_ack_q, resp_stb_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot, cur_onehot;
  logic [31:0]      a_arr [N_REQ];
  logic [31:0]      b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign a_arr[gi]       = req_a[32*gi +: 32];
      assign b_arr[gi]       = req_b[32*gi +: 32];
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
      assign cur_onehot[gi]  = (cur_id_q == IDX_W'(gi));
    end
  endgenerate

  fpu_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_stb),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The adder samples input_stb before it raises input_ack, and drops its result if
  // output_ack arrives early, so both strobes are gated by the adder's own handshake.
  assign fpu_input_stb  = (state_q == ISSUE) && fpu_input_ack;
  assign fpu_output_ack = (state_q == WAIT_RES) && fpu_output_stb;
  assign fpu_input_a    = op_a_q;
  assign fpu_input_b    = op_b_q;
  assign req_ack        = req_ack_q;
  assign resp_stb       = resp_stb_q;
  assign resp_z         = res_z_q;
  assign busy           = (state_q != IDLE);
  assign cur_id         = cur_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_z_q    <= '0;
      req_ack_q  <= '0;
      resp_stb_q <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            req_ack_q <= pick_onehot;
            op_a_q    <= a_arr[pick_idx];
            op_b_q    <= b_arr[pick_idx];
            cur_id_q  <= pick_idx;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (fpu_input_stb) state_q <= WAIT_RES;
        end
        WAIT_RES: begin
          if (fpu_output_stb) begin
            res_z_q    <= fpu_output_z;
            resp_stb_q <= cur_onehot;
            state_q    <= DELIVER;
          end
        end
        DELIVER: begin
          if (resp_ack[cur_id_q]) begin
            resp_stb_q <= '0;
            rr_ptr_q   <= (cur_id_q == IDX_W'(N_REQ - 1)) ? '0 : cur_id_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with a table-driven multi-cycle adder model.
module tb_fpu_add_arbiter;
  import fpu_add_arbiter_pkg::*;

  localparam int N = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic [N-1:0]  req_stb = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  resp_stb;
  logic [31:0]   resp_z;
  logic [N-1:0]  resp_ack = '0;
  logic [31:0]   fpu_input_a, fpu_input_b;
  logic          fpu_input_stb;
  logic          fpu_input_ack;
  logic [31:0]   fpu_output_z;
  logic          fpu_output_stb;
  logic          fpu_output_ack;
  logic          busy;
  logic [1:0]    cur_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .resp_stb(resp_stb), .resp_z(resp_z), .resp_ack(resp_ack),
    .fpu_input_a(fpu_input_a), .fpu_input_b(fpu_input_b),
    .fpu_input_stb(fpu_input_stb), .fpu_input_ack(fpu_input_ack),
    .fpu_output_z(fpu_output_z), .fpu_output_stb(fpu_output_stb),
    .fpu_output_ack(fpu_output_ack), .busy(busy), .cur_id(cur_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Adder model: hand-computed sums for every operand pair the bench issues.
  function automatic logic [31:0] add_table(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3FC00000, 32'h3F000000}: return 32'h40000000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'hBF800000, 32'h3F800000}: return 32'h00000000;
      {FP_QNAN,      FP_ONE}:       return FP_QNAN;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  int          m_st;
  int          m_cnt;
  logic [31:0] m_a, m_b;

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_a <= '0; m_b <= '0;
      fpu_input_ack <= 1'b0; fpu_output_stb <= 1'b0; fpu_output_z <= '0;
    end else begin
      case (m_st)
        0: begin
          fpu_input_ack <= 1'b1;
          if (fpu_input_stb && fpu_input_ack) begin
            m_a <= fpu_input_a; m_b <= fpu_input_b;
            fpu_input_ack <= 1'b0; m_cnt <= 3; m_st <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            fpu_output_z <= add_table(m_a, m_b);
            fpu_output_stb <= 1'b1;
            m_st <= 2;
          end
        end
        default: begin
          if (fpu_output_stb && fpu_output_ack) begin
            fpu_output_stb <= 1'b0;
            m_st <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fpu_input_stb)  check("in_hs",  32'(fpu_input_ack), 32'd1);
      if (fpu_output_ack) check("out_hs", 32'(fpu_output_stb), 32'd1);
    end
  end

  // Requester agent state: per-port op lists, progress counters and grant log.
  logic [31:0] op_a [N][8];
  logic [31:0] op_b [N][8];
  logic [31:0] op_z [N][8];
  int          n_ops [N];
  int          issued [N];
  int          done [N];
  logic [N-1:0] auto_ack;
  int          grants [$];

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      n_ops[i] = 0; issued[i] = 0; done[i] = 0;
    end
    auto_ack = '1;
    grants.delete();
  endtask

  task automatic add_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z);
    op_a[i][n_ops[i]] = a;
    op_b[i][n_ops[i]] = b;
    op_z[i][n_ops[i]] = z;
    n_ops[i]++;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (done[i] != n_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk);
    if (rst) begin
      resp_ack = '0;
      req_stb  = '0;
    end else begin
      if (|resp_stb) check("resp_onehot", 32'($countones(resp_stb)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          grants.push_back(i);
          issued[i]++;
          $display("grant req%0d", i);
        end
      end
      for (int i = 0; i < N; i++) begin
        resp_ack[i] = 1'b0;
        if (resp_stb[i] && auto_ack[i]) begin
          if (done[i] < n_ops[i]) begin
            $display("resp  req%0d z=%h", i, resp_z);
            check($sformatf("resp%0d_z", i), resp_z, op_z[i][done[i]]);
            done[i]++;
          end else begin
            check($sformatf("spurious_resp%0d", i), 32'd1, 32'd0);
          end
          resp_ack[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        req_stb[i] = (issued[i] < n_ops[i]);
        if (req_stb[i]) begin
          req_a[32*i +: 32] = op_a[i][issued[i]];
          req_b[32*i +: 32] = op_b[i][issued[i]];
        end
      end
    end
  endtask

  task automatic run_ops(input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    if (!all_done()) check("timeout", 32'd0, 32'd1);
    step();
    step();
  endtask

  task automatic check_grants(input string tag, input int exp [$]);
    check({tag, "_count"}, 32'(grants.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < grants.size(); k++)
      check($sformatf("%s_%0d", tag, k), 32'(grants[k]), 32'(exp[k]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_cur_id"},   32'(cur_id), 32'd0);
    check({tag, "_req_ack"},  32'(req_ack), 32'd0);
    check({tag, "_resp_stb"}, 32'(resp_stb), 32'd0);
    check({tag, "_resp_z"},   resp_z, 32'd0);
    check({tag, "_in_a"},     fpu_input_a, 32'd0);
    check({tag, "_in_b"},     fpu_input_b, 32'd0);
    check({tag, "_in_stb"},   32'(fpu_input_stb), 32'd0);
    check({tag, "_out_ack"},  32'(fpu_output_ack), 32'd0);
  endtask

  initial begin
    logic [31:0] hold_z;
    int          n;
    clear_ops();
    rst = 1;
    repeat (3) step();
    rst = 0;
    check_reset_outputs("reset");

    // All four at once from rr_ptr=0.
    clear_ops();
    add_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    add_op(1, 32'h40000000, 32'h40000000, 32'h40800000);
    add_op(2, 32'h3FC00000, 32'h3F000000, 32'h40000000);
    add_op(3, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    run_ops(300);
    check_grants("all4", '{0, 1, 2, 3});

    // Single op on requester 0.
    clear_ops();
    add_op(0, FP_ONE, 32'h40000000, 32'h40400000);
    run_ops(100);
    check_grants("single", '{0});

    // Lone op on 1 leaves rr_ptr at 2 before the persistent pair.
    clear_ops();
    add_op(1, FP_ONE, FP_ONE, 32'h40000000);
    run_ops(100);
    clear_ops();
    add_op(1, FP_ONE, FP_ONE, 32'h40000000);
    add_op(1, 32'h40000000, 32'h40000000, 32'h40800000);
    add_op(3, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    add_op(3, FP_ONE, 32'h40000000, 32'h40400000);
    run_ops(300);
    check_grants("persist", '{3, 1, 3, 1});

    // Backpressure on requester 0 while requester 1 waits.
    clear_ops();
    auto_ack[0] = 1'b0;
    add_op(0, FP_ONE, 32'h40000000, 32'h40400000);
    add_op(1, 32'h3FC00000, 32'h3F000000, 32'h40000000);
    n = 0;
    while (!resp_stb[0] && n < 60) begin
      step();
      n++;
    end
    check("bp_resp_seen", 32'(resp_stb[0]), 32'd1);
    hold_z = resp_z;
    check("bp_z", hold_z, 32'h40400000);
    for (int c = 0; c < 20; c++) begin
      step();
      check("bp_stb",     32'(resp_stb[0]), 32'd1);
      check("bp_z_hold",  resp_z, hold_z);
      check("bp_busy",    32'(busy), 32'd1);
      check("bp_req_ack", 32'(req_ack), 32'd0);
      check("bp_in_stb",  32'(fpu_input_stb), 32'd0);
    end
    auto_ack[0] = 1'b1;
    run_ops(200);
    check_grants("bp", '{0, 1});

    // Signed cancellation to zero and NaN pass-through.
    clear_ops();
    add_op(2, 32'hBF800000, FP_ONE, 32'h00000000);
    add_op(3, FP_QNAN, FP_ONE, FP_QNAN);
    run_ops(200);

    // Reset while waiting on the adder result.
    clear_ops();
    add_op(2, FP_ONE, FP_ONE, 32'h40000000);
    n = 0;
    while (!(issued[2] == 1 && busy && !fpu_input_ack && !fpu_output_stb) && n < 60) begin
      step();
      n++;
    end
    check("midop_reached", 32'(issued[2]), 32'd1);
    rst = 1;
    clear_ops();
    step();
    rst = 0;
    check_reset_outputs("midop_rst");
    clear_ops();
    add_op(2, FP_ONE, FP_ONE, 32'h40000000);
    run_ops(100);
    check_grants("after_rst", '{2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one fpu_adder instance between N_REQ requesters using round-robin arbitration.
- Accepts operand pairs over per-requester stb/ack handshakes and drives the adder's input handshake.
- Captures the adder's result and returns it to the requester that issued the operation.
- One operation is outstanding at a time, because the adder is a non-pipelined multi-cycle FSM.
- Sits between the matrix-multiply accumulation units and the single shared adder.

Parameters:
N_REQ, 4, number of requester ports (2..16)
IDX_W, $clog2(N_REQ), width of the requester index

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_stb  input  N_REQ  per-requester operand-valid
req_a  input  N_REQ*32  packed operand A, requester i at [32*i+:32]
req_b  input  N_REQ*32  packed operand B
req_ack  output  N_REQ  one-cycle operand-accepted pulse
resp_stb  output  N_REQ  result-valid, one-hot to the owning requester
resp_z  output  32  result, valid while any resp_stb bit is set
resp_ack  input  N_REQ  result-taken, per requester
fpu_input_a  output  32  to adder input_a
fpu_input_b  output  32  to adder input_b
fpu_input_stb  output  1  to adder input_stb
fpu_input_ack  input  1  from adder input_ack
fpu_output_z  input  32  from adder output_z
fpu_output_stb  input  1  from adder output_stb
fpu_output_ack  output  1  to adder output_ack
busy  output  1  high whenever the state is not IDLE
cur_id  output  IDX_W  index of the current grant

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - State goes to IDLE and rr_ptr to 0.
  - All outputs are 0, including operand and result registers and cur_id.
  - The adder shares clk/rst, so a reset mid-operation aborts both sides.
  - No req_ack or resp_stb is issued for an aborted operation.
- FSM states: IDLE, ISSUE, WAIT_RES, DELIVER.
- IDLE:
  - If any req_stb is set, pick the first set bit searching upward from rr_ptr, wrapping N_REQ-1 to 0.
  - On that pick: pulse req_ack[g]=1 for one cycle, latch req_a/req_b[g] into op_a/op_b, set cur_id=g, and go to ISSUE.
  - With no request, remain in IDLE.
  - Earliest grant is the first cycle after req_stb rises (req_ack is registered).
- ISSUE:
  - fpu_input_a/b = op_a/op_b.
  - fpu_input_stb = (state==ISSUE) && fpu_input_ack. It is combinational and must never be high while fpu_input_ack=0, because the adder samples input_stb in its get_input state before input_ack rises.
  - Transfer happens when fpu_input_stb && fpu_input_ack, then go to WAIT_RES.
- WAIT_RES:
  - fpu_output_ack = (state==WAIT_RES) && fpu_output_stb. It is combinational and must not be asserted before output_stb, or the adder drops the result.
  - On fpu_output_stb: latch fpu_output_z into res_z and go to DELIVER.
- DELIVER:
  - resp_stb[cur_id]=1, resp_z=res_z, both held stable until resp_ack[cur_id]=1.
  - On ack: deassert resp_stb the next cycle, set rr_ptr=(cur_id+1) mod N_REQ, and go to IDLE.
  - resp_ack bits of other requesters are ignored.
- Fairness: a requester holding req_stb waits at most N_REQ-1 other operations.
- Simultaneous events:
  - req_stb from other requesters during ISSUE/WAIT_RES/DELIVER is held off; no req_ack is issued.
  - A requester may present a new req_stb while its resp_stb is pending; it is granted only after returning to IDLE.
- Requesters must hold req_stb, req_a and req_b stable until req_ack.
- Results are passed unmodified: NaN, inf and zero come straight from the adder.
- Minimum turnaround per operation is 3 arbiter cycles plus the adder latency plus the resp_ack delay.

Decomposition:
- global_defs:
  - fpu_arb_state_t enum (IDLE, ISSUE, WAIT_RES, DELIVER), logic [1:0].
  - FPU_NUM_REQ constant, default 4.
  - FP32 constants FP_ONE=32'h3F800000 and FP_QNAN=32'hFFC00000 for benches.
- Sub-module fpu_rr_pick:
  - Combinational inputs: req vector and rr_ptr.
  - Outputs: valid and grant index.
  - Double-width mask and priority-encode, so it is reusable for multiplier sharing.

Test Plan:
- Single op: req 0 with a=0x3F800000, b=0x40000000 → req_ack[0] one cycle, then resp_stb[0] with resp_z=0x40400000; other resp_stb bits stay 0.
- All 4 requesters assert at once after reset → grant order 0,1,2,3; each resp_z routed to its issuer (e.g. req2 with 0x3FC00000+0x3F000000 → 0x40000000 on resp_stb[2]).
- Persistent req_stb on 1 and 3, rr_ptr=2 → grants 3,1,3,1, with no consecutive repeat while the other is pending.
- Backpressure: hold resp_ack[0]=0 for 20 cycles → resp_stb[0] and resp_z stay stable, busy=1, no new req_ack issued, fpu_input_stb stays 0.
- Handshake check: assertion that fpu_input_stb implies fpu_input_ack and fpu_output_ack implies fpu_output_stb; -1.0+1.0 (0xBF800000, 0x3F800000) → 0x00000000.
- Reset mid-op: rst during WAIT_RES → next cycle state IDLE, all outputs 0; a subsequent 1.0+1.0 returns 0x40000000 on the correct port.
